// File: rtl/trisc_sequencer.sv
// trisc_sequencer: fetch/decode/execute microsequencer for the TRISC datapath.
// Drives the registered control word C[0:14] from the IR opcode and the ACC zero flag.
// READ_LAT sets the RAM read latency; READ_LAT-1 wait states follow every read strobe.
// Optional single-step input: define TRISC_SEQ_STEP_EN to add the Step port.
// C is computed from the state being entered, so each C word lines up with its own state.
module trisc_sequencer #(
  parameter int OPW      = 4,
  parameter int CW       = 15,
  parameter int READ_LAT = 1
) (
  input  logic           SysClock,
  input  logic           Reset,
  input  logic           Run,
`ifdef TRISC_SEQ_STEP_EN
  input  logic           Step,
`endif
  input  logic [OPW-1:0] Opcode,
  input  logic           AccZero,
  output logic [0:CW-1]  C,
  output logic           Halted,
  output logic           InstrDone,
  output logic [2:0]     State
);

  typedef enum logic [3:0] {
    S_INIT, S_CLR, S_IDLE, S_F0, S_FW, S_F1, S_DEC,
    S_E0, S_EW, S_E1, S_E2, S_HALT
  } state_t;

  localparam bit         HAS_WAIT  = (READ_LAT > 1);
  localparam logic [1:0] WAIT_LOAD = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  state_t        state, state_next, after_instr;
  logic [1:0]    wcnt, wcnt_next;
  logic          run_low, run_low_next;
  logic          step_mode, step_mode_next;
  logic [0:CW-1] c_next;
  logic          done_next;
  logic          is_alu, is_read;
  logic          step_edge;

  assign is_alu  = (Opcode[3:2] == 2'b01);
  assign is_read = is_alu || (Opcode == 4'h2);

  // An instruction ends in F0 for free-running mode, IDLE when stopped or single-stepping
  assign after_instr = (Run && !step_mode) ? S_F0 : S_IDLE;

`ifdef TRISC_SEQ_STEP_EN
  logic step_q;

  // Previous Step level for rising-edge detection
  always_ff @(posedge SysClock or negedge Reset) begin
    if (!Reset) step_q <= 1'b0;
    else        step_q <= Step;
  end

  assign step_edge = Step & ~step_q;
`else
  assign step_edge = 1'b0;
`endif

  // Next-state selection, wait-state counting and HALT re-arm tracking
  always_comb begin
    state_next     = state;
    wcnt_next      = wcnt;
    run_low_next   = run_low;
    step_mode_next = step_mode;
    case (state)
      S_INIT: state_next = S_CLR;
      S_CLR:  state_next = S_IDLE;
      S_IDLE: begin
        step_mode_next = 1'b0;
        if (Run) begin
          state_next = S_F0;
        end else if (step_edge) begin
          state_next     = S_F0;
          step_mode_next = 1'b1;
        end
      end
      S_F0: begin
        if (HAS_WAIT) begin
          state_next = S_FW;
          wcnt_next  = WAIT_LOAD;
        end else begin
          state_next = S_F1;
        end
      end
      S_FW: begin
        if (wcnt == 2'd0) state_next = S_F1;
        else              wcnt_next  = wcnt - 2'd1;
      end
      S_F1: state_next = S_DEC;
      S_DEC: begin
        if (Opcode == 4'hF) begin
          state_next     = S_HALT;
          run_low_next   = 1'b0;
          step_mode_next = 1'b0;
        end else begin
          state_next = S_E0;
        end
      end
      S_E0: begin
        if (is_read) begin
          if (HAS_WAIT) begin
            state_next = S_EW;
            wcnt_next  = WAIT_LOAD;
          end else begin
            state_next = S_E1;
          end
        end else begin
          state_next = after_instr;
        end
      end
      S_EW: begin
        if (wcnt == 2'd0) state_next = S_E1;
        else              wcnt_next  = wcnt - 2'd1;
      end
      S_E1: state_next = is_alu ? S_E2 : after_instr;
      S_E2: state_next = after_instr;
      S_HALT: begin
        // Resume needs a fresh Run rising edge, so Run must be seen low first
        if (!Run)         run_low_next = 1'b1;
        else if (run_low) state_next   = S_F0;
      end
      default: state_next = S_INIT;
    endcase
  end

  // Control word and done pulse for the state about to be entered
  always_comb begin
    c_next    = '0;
    done_next = 1'b0;
    case (state_next)
      S_CLR: begin
        c_next[0] = 1'b1;
        c_next[8] = 1'b1;
      end
      S_F0: begin
        c_next[3] = 1'b1;
        c_next[4] = 1'b1;
      end
      S_F1: begin
        c_next[7] = 1'b1;
        c_next[2] = 1'b1;
      end
      S_E0: begin
        done_next = !is_read;
        case (Opcode)
          4'h0:                      c_next[8] = 1'b1;
          4'h1:                      c_next[9] = 1'b1;
          4'h2, 4'h4, 4'h5, 4'h6, 4'h7: c_next[4] = 1'b1;
          4'h3: begin
            c_next[4] = 1'b1;
            c_next[5] = 1'b1;
          end
          4'h8:                      c_next[1] = 1'b1;
          4'h9:                      c_next[1] = AccZero;
          default: ;
        endcase
      end
      S_E1: begin
        if (is_alu) begin
          c_next[14] = 1'b1;
          c_next[13] = Opcode[1];
          c_next[12] = Opcode[0];
        end else begin
          c_next[11] = 1'b1;
          done_next  = 1'b1;
        end
      end
      S_E2: begin
        c_next[10] = 1'b1;
        c_next[11] = 1'b1;
        done_next  = 1'b1;
      end
      S_HALT: done_next = (state == S_DEC);
      default: ;
    endcase
  end

  // State and registered outputs; reset drops any pending RAM write at once
  always_ff @(posedge SysClock or negedge Reset) begin
    if (!Reset) begin
      state     <= S_INIT;
      wcnt      <= 2'd0;
      run_low   <= 1'b0;
      step_mode <= 1'b0;
      C         <= '0;
      Halted    <= 1'b0;
      InstrDone <= 1'b0;
    end else begin
      state     <= state_next;
      wcnt      <= wcnt_next;
      run_low   <= run_low_next;
      step_mode <= step_mode_next;
      C         <= c_next;
      Halted    <= (state_next == S_HALT);
      InstrDone <= done_next;
    end
  end

  // Debug display code: 0 INIT, 1 IDLE, 2 fetch, 3 DEC, 4 E0(+wait), 5 E1, 6 E2, 7 HALT
  always_comb begin
    State = 3'd0;
    case (state)
      S_INIT, S_CLR:    State = 3'd0;
      S_IDLE:           State = 3'd1;
      S_F0, S_FW, S_F1: State = 3'd2;
      S_DEC:            State = 3'd3;
      S_E0, S_EW:       State = 3'd4;
      S_E1:             State = 3'd5;
      S_E2:             State = 3'd6;
      S_HALT:           State = 3'd7;
      default:          State = 3'd0;
    endcase
  end

endmodule
